// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick every D cycles and a square wave
// toggling on each tick; divisors are shadowed so that a running channel
// finishes its current period before switching to a new divisor.
module tick_gen #(
    parameter int unsigned  CHANNELS    = 4,
    parameter int unsigned  CNT_WIDTH   = 24,
    parameter int unsigned  DEFAULT_DIV = 5_000_000,
    parameter bit           EN_RESET    = 1'b1,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic                 cfg_en,
    input  logic                 sync,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  sq,
    output logic [CHANNELS-1:0]  pending
);

    logic [CNT_WIDTH-1:0] cnt     [CHANNELS];
    logic [CNT_WIDTH-1:0] div_act [CHANNELS];
    logic [CNT_WIDTH-1:0] div_shd [CHANNELS];
    logic [CNT_WIDTH-1:0] last    [CHANNELS];
    logic [CHANNELS-1:0]  en;
    logic [CHANNELS-1:0]  wr_hit;
    logic [CHANNELS-1:0]  wrap;

    // Per-channel write decode and end-of-period detection (divisor 0 acts as 1).
    always_comb begin
        wr_hit = '0;
        wrap   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            last[i]   = (div_act[i] == '0) ? '0 : div_act[i] - CNT_WIDTH'(1);
            wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            wrap[i]   = (cnt[i] == last[i]);
        end
    end

    // Channel counters, divisor shadowing, sync realignment and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= CNT_WIDTH'(DEFAULT_DIV);
                div_shd[i] <= CNT_WIDTH'(DEFAULT_DIV);
            end
            en      <= {CHANNELS{EN_RESET}};
            pending <= '0;
            tick    <= '0;
            sq      <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!en[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                    sq[i]   <= 1'b0;
                    if (wr_hit[i]) begin
                        en[i]      <= cfg_en;
                        div_act[i] <= cfg_div;
                        pending[i] <= 1'b0;
                    end
                end else if (wr_hit[i] && !cfg_en) begin
                    en[i]      <= 1'b0;
                    div_act[i] <= cfg_div;
                    pending[i] <= 1'b0;
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    sq[i]      <= 1'b0;
                end else if (sync) begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    sq[i]      <= 1'b0;
                    pending[i] <= 1'b0;
                    if (wr_hit[i]) begin
                        div_act[i] <= cfg_div;
                    end else if (pending[i]) begin
                        div_act[i] <= div_shd[i];
                    end
                end else begin
                    if (wrap[i]) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
                        sq[i]   <= ~sq[i];
                    end else begin
                        cnt[i]  <= cnt[i] + CNT_WIDTH'(1);
                        tick[i] <= 1'b0;
                    end
                    // A write landing on the wrap edge supersedes the older shadow;
                    // the new value is applied at the following wrap.
                    if (wr_hit[i]) begin
                        div_shd[i] <= cfg_div;
                        pending[i] <= 1'b1;
                    end else if (wrap[i] && pending[i]) begin
                        div_act[i] <= div_shd[i];
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: event-based reference model (absolute next-tick edge
// per channel) checked every cycle, plus hand-computed directed expectations.
module tb_tick_gen;

    localparam int CH  = 3;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [CW-1:0] cfg_div = '0;
    logic          cfg_en = 1'b0;
    logic          sync = 1'b0;
    logic [CH-1:0] tick;
    logic [CH-1:0] sq;
    logic [CH-1:0] pending;

    int total = 0;
    int bad   = 0;

    tick_gen #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (DEF),
        .EN_RESET    (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_en  (cfg_en),
        .sync    (sync),
        .tick    (tick),
        .sq      (sq),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Reference model: edge count since reset and the absolute edge of each channel's next tick.
    int            m_e = 0;
    bit            m_valid = 1'b0;
    bit [CH-1:0]   m_en, m_pend, m_tick, m_sq;
    int            m_div  [CH];
    int            m_shd  [CH];
    int            m_next [CH];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0;
            m_valid = 1'b1;
            for (int c = 0; c < CH; c++) begin
                m_en[c] = 1'b1; m_pend[c] = 1'b0; m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                m_div[c] = DEF; m_shd[c] = DEF; m_next[c] = eff(DEF);
            end
        end else if (m_valid) begin
            m_e++;
            for (int c = 0; c < CH; c++) begin
                bit wr;
                wr = cfg_we && (int'(cfg_ch) == c);
                if (!m_en[c]) begin
                    m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                    if (wr) begin
                        m_en[c] = cfg_en; m_div[c] = int'(cfg_div); m_pend[c] = 1'b0;
                        m_next[c] = m_e + eff(m_div[c]);
                    end
                end else if (wr && !cfg_en) begin
                    m_en[c] = 1'b0; m_div[c] = int'(cfg_div); m_pend[c] = 1'b0;
                    m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                end else if (sync) begin
                    m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                    if (wr) m_div[c] = int'(cfg_div);
                    else if (m_pend[c]) m_div[c] = m_shd[c];
                    m_pend[c] = 1'b0;
                    m_next[c] = m_e + eff(m_div[c]);
                end else begin
                    if (m_e == m_next[c]) begin
                        m_tick[c] = 1'b1; m_sq[c] = ~m_sq[c];
                        if (m_pend[c] && !wr) begin
                            m_div[c] = m_shd[c]; m_pend[c] = 1'b0;
                        end
                        m_next[c] = m_e + eff(m_div[c]);
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                    if (wr) begin
                        m_shd[c] = int'(cfg_div); m_pend[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            total++;
            if (tick !== m_tick) begin
                bad++; $display("FAIL model_tick edge=%0d got=%b exp=%b", m_e, tick, m_tick);
            end
            total++;
            if (sq !== m_sq) begin
                bad++; $display("FAIL model_sq edge=%0d got=%b exp=%b", m_e, sq, m_sq);
            end
            total++;
            if (pending !== m_pend) begin
                bad++; $display("FAIL model_pending edge=%0d got=%b exp=%b", m_e, pending, m_pend);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b exp=%b", name, m_e, got, exp);
        end
    endtask

    task automatic go_to(input int n);
        int guard;
        guard = 0;
        while (m_e < n && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (m_e != n) begin
            total++; bad++;
            $display("FAIL go_to edge=%0d want=%0d", m_e, n);
        end
    endtask

    task automatic wr(input int ch, input int dv, input bit en);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(dv); cfg_en = en;
    endtask

    task automatic wr_clr();
        cfg_we = 1'b0; cfg_en = 1'b0; cfg_div = '0; cfg_ch = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d", m_e);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset defaults, D=4 on all channels
        go_to(3);  chk("rst_tick", 8'(tick), 8'b000); chk("rst_sq", 8'(sq), 8'b000);
                   chk("rst_pend", 8'(pending), 8'b000);
        go_to(4);  chk("t4_tick", 8'(tick), 8'b111); chk("t4_sq", 8'(sq), 8'b111);
        wr(0, 2, 1'b1);
        go_to(5);  wr_clr(); chk("w5_pend", 8'(pending), 8'b001); chk("t5_tick", 8'(tick), 8'b000);
        go_to(8);  chk("t8_tick", 8'(tick), 8'b111); chk("t8_sq", 8'(sq), 8'b000);
                   chk("t8_pend", 8'(pending), 8'b000);
        go_to(10); chk("t10_tick", 8'(tick), 8'b001);
        go_to(11); chk("t11_tick", 8'(tick), 8'b000);
        go_to(12); chk("t12_tick", 8'(tick), 8'b111); chk("t12_sq", 8'(sq), 8'b110);

        // Disable ch1, then write divisor 0 with enable
        go_to(14); wr(1, 7, 1'b0);
        go_to(15); wr_clr(); chk("dis_tick1", 8'(tick[1]), 8'd0); chk("dis_sq1", 8'(sq[1]), 8'd0);
        go_to(16); wr(1, 0, 1'b1);
        go_to(17); wr_clr();
        go_to(18); chk("d0_tick1_a", 8'(tick[1]), 8'd1); chk("d0_sq1_a", 8'(sq[1]), 8'd1);
        go_to(19); chk("d0_tick1_b", 8'(tick[1]), 8'd1); chk("d0_sq1_b", 8'(sq[1]), 8'd0);

        // ch0 -> D=3, ch1 -> D=5 via shadow, then sync
        go_to(20); wr(0, 3, 1'b1);
        go_to(21); wr(1, 5, 1'b1); chk("sh_pend0", 8'(pending[0]), 8'd1);
        go_to(22); wr_clr(); chk("sh_pend1", 8'(pending[1]), 8'd1); chk("sh_pend0_clr", 8'(pending[0]), 8'd0);
        go_to(23); chk("sh_pend1_clr", 8'(pending[1]), 8'd0);
        go_to(29); sync = 1'b1;
        go_to(30); sync = 1'b0;
                   chk("sy_tick", 8'(tick), 8'b000); chk("sy_sq", 8'(sq), 8'b000);
                   chk("sy_pend", 8'(pending), 8'b000);
        go_to(33); chk("sy33", 8'(tick), 8'b001);
        go_to(34); chk("sy34", 8'(tick), 8'b100);
        go_to(35); chk("sy35", 8'(tick), 8'b010);
        go_to(36); chk("sy36", 8'(tick), 8'b001);

        // Sync together with a write to enabled ch2
        go_to(39); sync = 1'b1; wr(2, 6, 1'b1);
        go_to(40); sync = 1'b0; wr_clr();
                   chk("syw_pend", 8'(pending), 8'b000); chk("syw_tick", 8'(tick), 8'b000);
        go_to(45); chk("syw45", 8'(tick[2]), 8'd0);
        go_to(46); chk("syw46", 8'(tick[2]), 8'd1);

        // ch0 -> D=4 via shadow, disable at cnt=2, sync while disabled, re-enable
        go_to(49); wr(0, 4, 1'b1);
        go_to(50); wr_clr(); chk("p50_pend0", 8'(pending[0]), 8'd1);
        go_to(52); chk("p52_tick0", 8'(tick[0]), 8'd1); chk("p52_pend0", 8'(pending[0]), 8'd0);
        go_to(56); chk("p56_tick0", 8'(tick[0]), 8'd1);
        go_to(58); wr(0, 4, 1'b0);
        go_to(59); wr_clr(); chk("off_tick0", 8'(tick[0]), 8'd0); chk("off_sq0", 8'(sq[0]), 8'd0);
        go_to(60); sync = 1'b1;
        go_to(61); sync = 1'b0; wr(0, 4, 1'b1); chk("s61_tick", 8'(tick), 8'b000);
        go_to(62); wr_clr();
        go_to(65); chk("re65_tick0", 8'(tick[0]), 8'd0);
        go_to(66); chk("re66_tick", 8'(tick), 8'b011);

        // Out-of-range channel write is ignored
        go_to(69); wr(3, 1, 1'b0);
        go_to(70); wr_clr(); chk("oor_pend", 8'(pending), 8'b000);
        go_to(74); chk("oor_tick", 8'(tick), 8'b001);

        // Reset overrides simultaneous write and sync
        go_to(76); rst = 1'b1; sync = 1'b1; wr(0, 1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; sync = 1'b0; wr_clr();
        chk("rr_tick", 8'(tick), 8'b000); chk("rr_sq", 8'(sq), 8'b000);
        chk("rr_pend", 8'(pending), 8'b000);
        go_to(1);  chk("rr1_tick", 8'(tick), 8'b000);
        go_to(3);  chk("rr3_tick", 8'(tick), 8'b000);
        go_to(4);  chk("rr4_tick", 8'(tick), 8'b111);

        // All-ones divisor on ch2: period 255
        go_to(9);  wr(2, 255, 1'b1);
        go_to(10); wr_clr(); chk("ff_pend", 8'(pending[2]), 8'd1);
        go_to(12); chk("ff12_tick2", 8'(tick[2]), 8'd1); chk("ff12_pend", 8'(pending[2]), 8'd0);
        go_to(266); chk("ff266_tick2", 8'(tick[2]), 8'd0);
        go_to(267); chk("ff267_tick2", 8'(tick[2]), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
